// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Holds the sequencer state encoding and the shared-counter width calculation.
package pll_reset_seq_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  // One counter serves every timed state, so size it for the longest interval.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_bit.sv
// Single-bit synchroniser: a STAGES-deep flop chain with synchronous reset to 0.
// Kept generic so other asynchronous status bits can reuse it.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses PLL reset, qualifies lock, releases system reset,
// and retries a bounded number of times before latching failure.
//
// state  | meaning
// PLLRST | holding the PLL in reset for PLL_RST_CYCLES
// WAIT   | PLL released, waiting for synchronised lock or timeout
// STABLE | lock seen, counting consecutive locked cycles
// RUN    | system reset released, watching for loss of lock
// FAIL   | retries exhausted; held until reset
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pll_lock_i,
  output logic               pll_reset_o,
  output logic               sys_reset_o,
  output logic               ready_o,
  output logic               lost_o,
  output logic               fail_o,
  output logic [RETRY_W-1:0] retries_o
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  logic lock_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic               pll_reset_q, pll_reset_d;
  logic               sys_reset_q, sys_reset_d;
  logic               ready_q, ready_d;
  logic               lost_q, lost_d;
  logic               fail_q, fail_d;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clock(clock),
    .reset(reset),
    .d_i  (pll_lock_i),
    .q_o  (lock_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_PLLRST;
      cnt_q       <= '0;
      retries_q   <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      lost_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      lost_q      <= lost_d;
      fail_q      <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    cnt_d     = cnt_q + CNT_W'(1);
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Lock takes priority over a timeout landing in the same cycle.
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retries_q < RETRY_MAX) begin
            state_d = ST_PLLRST;
            if (retries_q != RETRY_SAT) retries_d = retries_q + RETRY_W'(1);
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) state_d = ST_PLLRST;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_PLLRST;
      end
    endcase
    if (state_d != state_q || state_q == ST_RUN || state_q == ST_FAIL) begin
      cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    pll_reset_d = (state_d == ST_PLLRST) || (state_d == ST_FAIL);
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
    lost_d      = (state_q == ST_RUN) && (state_d == ST_PLLRST);
  end

  assign pll_reset_o = pll_reset_q;
  assign sys_reset_o = sys_reset_q;
  assign ready_o     = ready_q;
  assign lost_o      = lost_q;
  assign fail_o      = fail_q;
  assign retries_o   = retries_q;

endmodule
